// File: rtl/pb_iteration_scheduler.sv
// pb_iteration_scheduler: walks one loop dimension from a start bound to an
// end bound, one value per cycle, and emits a transaction for every value that
// falls inside at least one program-block window.
//
// Handshake: a transfer happens on a rising edge where out_valid & out_ready.
// Once out_valid is high, out_ivar/out_hit/out_idx hold steady until that
// transfer; out_valid never drops without a transfer except on abort or reset.
module pb_iteration_scheduler #(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int NUM_PB                   = 4,
  parameter int PB_IDX_W                 = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cfg_we,
  input  logic [PB_IDX_W-1:0]                 cfg_idx,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] cfg_min,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] cfg_max,
  input  logic                                cfg_ignore,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] ivar_start,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] ivar_end,
  input  logic                                start,
  input  logic                                abort,
  output logic                                busy,
  output logic                                done,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ITERATION_VARIABLE_WIDTH-1:0] out_ivar,
  output logic [NUM_PB-1:0]                   out_hit,
  output logic [PB_IDX_W-1:0]                 out_idx,
  output logic [1:0]                          dbg_state
);
  localparam int W = ITERATION_VARIABLE_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state;
  logic signed [W-1:0]   counter;
  logic signed [W-1:0]   end_reg;
  logic signed [W-1:0]   win_min [NUM_PB];
  logic signed [W-1:0]   win_max [NUM_PB];
  logic [NUM_PB-1:0]     win_ign;
  logic [NUM_PB-1:0]     hit;
  logic [PB_IDX_W-1:0]   hit_idx;
  logic                  stall;

  assign stall     = out_valid & ~out_ready;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Window registers; writable only while idle so a scan sees a frozen config.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_PB; k++) begin
        win_min[k] <= '0;
        win_max[k] <= '0;
      end
      win_ign <= '1;
    end else if (cfg_we && (state == IDLE) && (32'(cfg_idx) < NUM_PB)) begin
      win_min[cfg_idx] <= cfg_min;
      win_max[cfg_idx] <= cfg_max;
      win_ign[cfg_idx] <= cfg_ignore;
    end
  end

  // Signed inclusive window test of the current counter against every window.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_PB; k++) begin
      hit[k] = win_ign[k] | ((counter >= win_min[k]) && (counter <= win_max[k]));
    end
  end

  // Lowest-index hit window; scanning downward lets the lowest index win.
  always_comb begin
    hit_idx = '0;
    for (int k = NUM_PB - 1; k >= 0; k--) begin
      if (hit[k]) hit_idx = PB_IDX_W'(k);
    end
  end

  // Scan controller and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      end_reg   <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_ivar  <= '0;
      out_hit   <= '0;
      out_idx   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            counter <= ivar_start;
            end_reg <= ivar_end;
            // An empty range skips straight to the drain/done step.
            state   <= ($signed(ivar_end) < $signed(ivar_start)) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else if (!stall) begin
            out_ivar  <= counter;
            out_hit   <= hit;
            out_idx   <= hit_idx;
            out_valid <= |hit;
            // Equality test before increment keeps the counter from wrapping
            // when the end bound is the largest signed value.
            if (counter == end_reg) state <= DRAIN;
            else                    counter <= counter + 1'b1;
          end
        end
        DRAIN: begin
          if (abort) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else if (!out_valid || out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
